// File: rtl/reg_file_bank.sv
// -----------------------------------------------------------------------------
// reg_file_bank
//   Multi-register bank: one write port, two registered read ports, optional
//   zero-gating of R0 on reads (ba_out) and a sequenced soft-clear sweep that
//   zeroes one register per cycle without using the global reset.
//
// Ports
//   clk         in   1       system clock, rising edge
//   clr         in   1       synchronous active-high reset, highest priority
//   wr_en       in   1       write request
//   wr_addr     in   ADDR_W  write address
//   wr_data     in   DATA_W  write data
//   rd_addr_a   in   ADDR_W  read port A address
//   rd_addr_b   in   ADDR_W  read port B address
//   ba_out      in   1       when high (and ZERO_REG_EN), reads of R0 return 0
//   sweep_req   in   1       start a soft-clear sweep (honoured in IDLE only)
//   rd_data_a   out  DATA_W  read port A data, one cycle latency
//   rd_data_b   out  DATA_W  read port B data, one cycle latency
//   busy        out  1       high while a sweep is in progress
//   sweep_done  out  1       high during the final sweep cycle
// -----------------------------------------------------------------------------
module reg_file_bank #(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 16,
  parameter int ADDR_W      = 4,
  parameter int ZERO_REG_EN = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              ba_out,
  input  logic              sweep_req,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy,
  output logic              sweep_done
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] rd_a_q, rd_b_q;

  logic              sweeping;
  logic              last_step;
  logic              wr_accept;

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_d    [2];

  assign sweeping  = (state_q == ST_SWEEP);
  assign last_step = sweeping && (ptr_q == LAST_PTR);

  // Writes are dropped while sweeping so the sweep leaves a fully zeroed bank.
  assign wr_accept = wr_en && !sweeping && (32'(wr_addr) < NUM_REGS);

  // ---------------------------------------------------------------------------
  // Sweep sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (sweep_req) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
        end
      end
      ST_SWEEP: begin
        // Pointer stops at the last register and returns to 0 for the next sweep.
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read port next-value selection (priority order matters: R0 gating first,
  // then out-of-range, then the register being cleared, then write bypass).
  // ---------------------------------------------------------------------------
  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_rd_port
      logic [DATA_W-1:0] value;

      always_comb begin
        value = '0;
        if ((ZERO_REG_EN != 0) && ba_out && (rd_addr[gi] == '0)) begin
          value = '0;
        end else if (!(32'(rd_addr[gi]) < NUM_REGS)) begin
          value = '0;
        end else if (sweeping && (rd_addr[gi] == ptr_q)) begin
          value = '0;
        end else if (wr_accept && (wr_addr == rd_addr[gi])) begin
          value = wr_data;
        end else begin
          value = regs_q[rd_addr[gi]];
        end
      end

      assign rd_d[gi] = value;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State, storage and read registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rd_a_q  <= rd_d[0];
      rd_b_q  <= rd_d[1];
      for (int i = 0; i < NUM_REGS; i++) begin
        if (sweeping && (ptr_q == ADDR_W'(i))) begin
          regs_q[i] <= '0;
        end else if (wr_accept && (wr_addr == ADDR_W'(i))) begin
          regs_q[i] <= wr_data;
        end
      end
    end
  end

  assign rd_data_a  = rd_a_q;
  assign rd_data_b  = rd_b_q;
  assign busy       = sweeping;
  assign sweep_done = last_step;

endmodule
